// File: rtl/mpit_pkg.sv
// mpit: shared register map, CTRL bit positions and the run/idle state type.
package mpit_pkg;

   localparam logic MPIT_CTRL  = 1'b0;
   localparam logic MPIT_COUNT = 1'b1;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_PER  = 1;
   localparam int CTRL_IE   = 2;
   localparam int CTRL_PEND = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic logic [15:0] lane_merge(
      input logic [15:0] old,
      input logic [15:0] nw,
      input logic [1:0]  sel
   );
      lane_merge = old;
      if (sel[0]) lane_merge[7:0] = nw[7:0];
      if (sel[1]) lane_merge[15:8] = nw[15:8];
   endfunction

endpackage

// File: rtl/mpit_prescaler.sv
// mpit_prescaler: divides clk_i by PRESCALE, one-cycle tick on wrap.
module mpit_prescaler #(
   parameter int PRESCALE = 100
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt_q;

   // With PRESCALE=1 the counter sits at 0 and LAST is 0: tick every cycle.
   assign tick_o = en_i && (cnt_q == LAST);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else if (clr_i || !en_i || tick_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + PW'(1);
      end
   end

endmodule

// File: rtl/mpit_wb.sv
// mpit_wb: programmable interval timer, Wishbone classic slave (CTRL/COUNT).
module mpit_wb
   import mpit_pkg::*;
#(
   parameter int PRESCALE  = 100,
   parameter int CNT_WIDTH = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   input  logic [31:0] wb_adr_i,
   input  logic [1:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   output logic        irq_o
);

   state_e               state_q, state_d;
   logic                 per_q, per_d;
   logic                 ie_q, ie_d;
   logic                 pend_q, pend_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [CNT_WIDTH-1:0] reload_q, reload_d;
   logic                 ack_q;
   logic [15:0]          dat_q;
   logic                 irq_q;

   logic        req, wr, wr_ctrl, wr_cnt;
   logic        tick, presc_clr;
   logic [15:0] ctrl_rd, rdata;
   logic        adr_unused;

   assign adr_unused = ^{wb_adr_i[31:2], wb_adr_i[0]};

   // A new request is only taken while ack is low: one ack per two cycles.
   assign req     = wb_cyc_i && wb_stb_i && !ack_q;
   assign wr      = req && wb_we_i;
   assign wr_ctrl = wr && (wb_adr_i[1] == MPIT_CTRL) && wb_sel_i[0];
   assign wr_cnt  = wr && (wb_adr_i[1] == MPIT_COUNT) && (|wb_sel_i);

   assign ctrl_rd = {12'h000, pend_q, ie_q, per_q, state_q == RUN};
   assign rdata   = (wb_adr_i[1] == MPIT_COUNT) ? count_q : ctrl_rd;

   assign presc_clr = wr_cnt ||
                      (wr_ctrl && (state_q == IDLE) && wb_dat_i[CTRL_EN]);

   mpit_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_presc (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (state_q == RUN),
      .clr_i  (presc_clr),
      .tick_o (tick)
   );

   always_comb begin
      state_d  = state_q;
      per_d    = per_q;
      ie_d     = ie_q;
      pend_d   = pend_q;
      count_d  = count_q;
      reload_d = reload_q;

      if (wr_ctrl && wb_dat_i[CTRL_PEND]) pend_d = 1'b0;

      // Expiry is applied after W1C so a coincident set wins.
      case (state_q)
         RUN: begin
            if (tick && !wr_cnt) begin
               if (count_q != '0) begin
                  count_d = count_q - CNT_WIDTH'(1);
               end else begin
                  pend_d = 1'b1;
                  if (per_q) count_d = reload_q;
                  else       state_d = IDLE;
               end
            end
         end
         default: ;
      endcase

      if (wr_ctrl) begin
         state_d = wb_dat_i[CTRL_EN] ? RUN : IDLE;
         per_d   = wb_dat_i[CTRL_PER];
         ie_d    = wb_dat_i[CTRL_IE];
      end

      if (wr_cnt) begin
         count_d  = lane_merge(count_q, wb_dat_i, wb_sel_i);
         reload_d = lane_merge(reload_q, wb_dat_i, wb_sel_i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         per_q    <= 1'b0;
         ie_q     <= 1'b0;
         pend_q   <= 1'b0;
         count_q  <= '0;
         reload_q <= '0;
         ack_q    <= 1'b0;
         dat_q    <= '0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         per_q    <= per_d;
         ie_q     <= ie_d;
         pend_q   <= pend_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         ack_q    <= req;
         dat_q    <= req ? rdata : '0;
         irq_q    <= pend_q && ie_q;
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;
   assign irq_o    = irq_q;

endmodule

// File: tb/tb_mpit_wb.sv
// tb_mpit_wb: bus vector table plus timed one-shot/periodic/edge sequences.
module tb_mpit_wb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] dat_w = '0;
   logic [31:0] adr = '0;
   logic [1:0]  sel = '0;
   logic        we = 1'b0;
   logic        cyc = 1'b0;
   logic        stb_a = 1'b0;
   logic        stb_b = 1'b0;
   logic [15:0] dat_a, dat_b;
   logic        ack_a, ack_b, irq_a, irq_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mpit_wb #(.PRESCALE(4)) u_dut (
      .clk_i(clk), .rst_i(rst_n), .wb_dat_i(dat_w), .wb_dat_o(dat_a),
      .wb_adr_i(adr), .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc),
      .wb_stb_i(stb_a), .wb_ack_o(ack_a), .irq_o(irq_a)
   );

   mpit_wb #(.PRESCALE(1)) u_edge (
      .clk_i(clk), .rst_i(rst_n), .wb_dat_i(dat_w), .wb_dat_o(dat_b),
      .wb_adr_i(adr), .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc),
      .wb_stb_i(stb_b), .wb_ack_o(ack_b), .irq_o(irq_b)
   );

   typedef struct {
      bit          dut;
      bit          chk;
      logic [15:0] exp;
      string       name;
   } sb_t;

   typedef struct {
      bit          we;
      bit          adr;
      logic [15:0] dat;
      logic [1:0]  sel;
      logic [15:0] exp;
   } vec_t;

   sb_t sb[$];

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard: every acked transfer pops one expectation.
   always @(negedge clk) begin
      sb_t e;
      if (ack_a || ack_b) begin
         if (sb.size() == 0) begin
            chk("spurious_ack", {14'b0, ack_b, ack_a}, 16'h0);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_ack"}, e.dut ? ack_b : ack_a, 16'h1);
            if (e.chk) chk(e.name, e.dut ? dat_b : dat_a, e.exp);
         end
      end
   end

   task automatic bus(input bit d, input bit w, input bit a,
                      input logic [15:0] dv, input logic [1:0] s,
                      input logic [15:0] exp, input string nm);
      sb_t e;
      int  n;
      logic got;
      @(negedge clk);
      e.dut = d; e.chk = !w; e.exp = exp; e.name = nm;
      sb.push_back(e);
      adr = 32'hF000000C | {30'b0, a, 1'b0};
      dat_w = dv; sel = s; we = w; cyc = 1'b1;
      if (d) stb_b = 1'b1;
      else   stb_a = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         got = d ? ack_b : ack_a;
      end while (!got && n < 8);
      if (!got) begin
         chk({nm, "_timeout"}, 16'h0, 16'h1);
         if (sb.size() > 0) e = sb.pop_back();
      end
      cyc = 1'b0; stb_a = 1'b0; stb_b = 1'b0; we = 1'b0;
   endtask

   task automatic irq_at(input bit d, input logic exp, input string nm);
      @(posedge clk);
      #1 chk(nm, d ? irq_b : irq_a, {15'b0, exp});
   endtask

   vec_t tbl[16];

   initial begin
      sb_t e;
      tbl[0]  = '{0, 0, 16'h0000, 2'b11, 16'h0000};
      tbl[1]  = '{0, 1, 16'h0000, 2'b11, 16'h0000};
      tbl[2]  = '{1, 1, 16'h0005, 2'b11, 16'h0000};
      tbl[3]  = '{0, 1, 16'h0000, 2'b11, 16'h0005};
      tbl[4]  = '{1, 1, 16'h1234, 2'b11, 16'h0000};
      tbl[5]  = '{1, 1, 16'hABCD, 2'b01, 16'h0000};
      tbl[6]  = '{0, 1, 16'h0000, 2'b11, 16'h12CD};
      tbl[7]  = '{1, 1, 16'h5600, 2'b10, 16'h0000};
      tbl[8]  = '{1, 1, 16'hFFFF, 2'b00, 16'h0000};
      tbl[9]  = '{0, 1, 16'h0000, 2'b00, 16'h56CD};
      tbl[10] = '{1, 0, 16'hFFF2, 2'b11, 16'h0000};
      tbl[11] = '{0, 0, 16'h0000, 2'b11, 16'h0002};
      tbl[12] = '{1, 0, 16'h0006, 2'b10, 16'h0000};
      tbl[13] = '{0, 0, 16'h0000, 2'b11, 16'h0002};
      tbl[14] = '{1, 0, 16'h0000, 2'b11, 16'h0000};
      tbl[15] = '{0, 0, 16'h0000, 2'b11, 16'h0000};

      repeat (3) @(negedge clk);
      chk("rst_ack", {14'b0, ack_b, ack_a}, 16'h0);
      chk("rst_irq", {14'b0, irq_b, irq_a}, 16'h0);
      chk("rst_dat", dat_a | dat_b, 16'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++)
         bus(0, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel,
             tbl[i].exp, $sformatf("vec%0d", i));

      // stb held past the ack: exactly one ack
      @(negedge clk);
      e.dut = 0; e.chk = 1; e.exp = 16'h56CD; e.name = "stb_hold";
      sb.push_back(e);
      adr = 32'hF000000E; we = 1'b0; cyc = 1'b1; stb_a = 1'b1;
      @(negedge clk); chk("hold_ack1", {15'b0, ack_a}, 16'h1);
      @(negedge clk); chk("hold_ack2", {15'b0, ack_a}, 16'h0);
      cyc = 1'b0; stb_a = 1'b0;
      @(negedge clk); chk("hold_ack3", {15'b0, ack_a}, 16'h0);

      // one-shot: COUNT=3, PRESCALE=4 -> PEND at +16, irq at +17
      bus(0, 1, 1, 16'h0003, 2'b11, 16'h0, "os_cnt");
      bus(0, 1, 0, 16'h0005, 2'b11, 16'h0, "os_ctrl");
      repeat (15) @(posedge clk);
      irq_at(0, 1'b0, "os_irq16");
      irq_at(0, 1'b1, "os_irq17");
      bus(0, 0, 0, 16'h0, 2'b11, 16'h000C, "os_ctrl_rd");
      bus(0, 0, 1, 16'h0, 2'b11, 16'h0000, "os_cnt_rd");
      repeat (10) @(posedge clk);
      bus(0, 0, 1, 16'h0, 2'b11, 16'h0000, "os_nowrap");
      bus(0, 1, 0, 16'h0000, 2'b11, 16'h0, "ie_off");
      irq_at(0, 1'b0, "ie_off_irq");
      bus(0, 0, 0, 16'h0, 2'b11, 16'h0008, "ie_off_rd");
      bus(0, 1, 0, 16'h0008, 2'b11, 16'h0, "w1c");
      bus(0, 0, 0, 16'h0, 2'b11, 16'h0000, "w1c_rd");

      // periodic: COUNT=2 -> expiry every 12 cycles
      bus(0, 1, 1, 16'h0002, 2'b11, 16'h0, "per_cnt");
      bus(0, 1, 0, 16'h0007, 2'b11, 16'h0, "per_ctrl");
      repeat (11) @(posedge clk);
      irq_at(0, 1'b0, "per_irq12");
      irq_at(0, 1'b1, "per_irq13");
      repeat (6) @(posedge clk);
      bus(0, 1, 0, 16'h000F, 2'b11, 16'h0, "per_w1c");
      irq_at(0, 1'b0, "per_irq21");
      repeat (2) @(posedge clk);
      irq_at(0, 1'b0, "per_irq24");
      irq_at(0, 1'b1, "per_irq25");
      repeat (10) @(posedge clk);
      bus(0, 1, 0, 16'h000F, 2'b11, 16'h0, "per_coll");
      irq_at(0, 1'b1, "coll_irq37");
      irq_at(0, 1'b1, "coll_irq38");
      bus(0, 0, 0, 16'h0, 2'b11, 16'h000F, "coll_rd");

      // reset while an ack is high
      @(negedge clk);
      adr = 32'hF000000C; we = 1'b0; cyc = 1'b1; stb_a = 1'b1;
      @(posedge clk);
      #1 chk("pre_rst_ack", {15'b0, ack_a}, 16'h1);
      rst_n = 1'b0;
      #1 chk("mid_rst_ack", {15'b0, ack_a}, 16'h0);
      chk("mid_rst_irq", {15'b0, irq_a}, 16'h0);
      cyc = 1'b0; stb_a = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus(0, 0, 0, 16'h0, 2'b11, 16'h0000, "post_rst_ctrl");
      bus(0, 0, 1, 16'h0, 2'b11, 16'h0000, "post_rst_cnt");

      // PRESCALE=1, RELOAD=0, periodic: PEND every cycle
      bus(1, 1, 1, 16'h0000, 2'b11, 16'h0, "e_cnt");
      bus(1, 1, 0, 16'h0007, 2'b11, 16'h0, "e_ctrl");
      irq_at(1, 1'b0, "e_irq1");
      irq_at(1, 1'b1, "e_irq2");
      bus(1, 1, 0, 16'h000F, 2'b11, 16'h0, "e_w1c");
      for (int i = 0; i < 3; i++)
         irq_at(1, 1'b1, $sformatf("e_irq_hold%0d", i));
      // COUNT write on a tick edge takes the written value
      bus(1, 1, 1, 16'h0100, 2'b11, 16'h0, "e_cwr");
      bus(1, 1, 0, 16'h0000, 2'b11, 16'h0, "e_stop");
      bus(1, 0, 1, 16'h0, 2'b11, 16'h00FE, "e_cnt_rd");
      bus(1, 0, 0, 16'h0, 2'b11, 16'h0008, "e_ctrl_rd");

      repeat (2) @(negedge clk);
      chk("sb_empty", 16'(sb.size()), 16'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
